timer_counter_param: RTL and testbench
======================================

// Module: timer_counter_param
// PURPOSE
//  Parametrised up/down timer counter; successor of the fixed 8-bit counter.
//  - Advances on a single-cycle tick from the prescaler (clk_ena).
//  - Adds run modes (free-run, auto-reload, one-shot) and a terminal-count pulse.
//  - Sits between the prescaler/clock-enable generator and the register/IRQ block.
// PARAMETERS
//  WIDTH      8   counter, load-value and compare-value width (>= 2)
//  RST_VAL    0   counter value after reset (WIDTH bits)
// PORTS
//  clk            in   1      system clock, all logic on posedge
//  rst            in   1      asynchronous, active-high reset
//  clk_ena        in   1      count tick, one clk cycle wide
//  start_counter  in   WIDTH  load / reload value
//  load           in   1      load start_counter into counter
//  up_down        in   1      1 = count up, 0 = count down
//  enable         in   1      count enable
//  mode           in   2      00 free-run, 01 auto-reload, 10 one-shot, 11 = free-run
//  clr_overflow   in   1      clear sticky overflow flag
//  clr_underflow  in   1      clear sticky underflow flag
//  count          out  WIDTH  current counter value
//  overflow       out  1      sticky: up-count wrapped past max
//  underflow      out  1      sticky: down-count wrapped past 0
//  tc_pulse       out  1      one-cycle pulse on every wrap/reload event
//  running        out  1      1 while counting is permitted (one-shot: 0 after expiry)
// BEHAVIOUR
//  - Reset values: count = RST_VAL; overflow, underflow, tc_pulse = 0; running = 1.
//  - Update precedence per posedge clk: load > tick (enable & clk_ena & running) > hold.
//  - load: count <= start_counter at the next edge; clk_ena is ignored for load.
//    Also sets running = 1 and does not touch the flags.
//  - Tick, up: count + 1. Tick, down: count - 1. Arithmetic is modulo 2^WIDTH.
//  - Wrap event: count == max & up, or count == 0 & down, on a tick.
//    - Free-run: count wraps (max -> 0, 0 -> max).
//    - Auto-reload: count <= start_counter instead of wrapping.
//    - One-shot: count holds the wrapped value; running <= 0 until the next load.
//  - A wrap event sets overflow (up) or underflow (down) on the same edge, visible
//    the cycle after the tick. tc_pulse = 1 for exactly that cycle.
//  - Example, down, start = 10: ticks 1..10 reach 0; tick 11 wraps and sets underflow.
//  - Flag clear: clr_* drops the flag next edge. Set and clear in the same cycle -> set wins.
//  - load and a tick in the same cycle -> load wins; no wrap event and no flag set.
//  - enable = 0 or clk_ena = 0: count holds; flags hold.
//  - mode or up_down changes take effect on the next tick; no state is flushed.
//  - rst asserted mid-count: all outputs return to reset values immediately (async).
//    Deassertion is synchronised externally.
// CONFIGURATION
//  TIMER_CMP_EN defined:
//    - Adds ports cmp_val (in, WIDTH), clr_cmp (in, 1) and cmp_match (out, 1, sticky).
//    - cmp_match sets on the edge where a tick or load makes count == cmp_val.
//    - Clear behaves like the other flags; set wins. Reset value 0.
//  TIMER_CMP_EN undefined: those ports and the compare logic are absent.
//    All other behaviour is identical.
// STRUCTURE
//  - timer_pkg: mode encodings (MODE_FREE, MODE_RELOAD, MODE_ONESHOT) and
//    localparam helpers for max count.
//  - Sub-module timer_sticky_flag (set/clr inputs, async rst, set-wins).
//    One instance each for overflow and underflow, plus cmp_match when enabled.
// TESTING  (WIDTH = 8, clk_ena every 2nd clk)
//  1. Reset held 5 clks, then released -> count = 0, overflow = 0, underflow = 0,
//     tc_pulse = 0, running = 1.
//  2. Free-run, down, enable = 1, load 10 on a tick cycle -> count = 10, no decrement
//     that cycle. 10 more ticks -> 0 with no flags. Tick 11 -> count = 255,
//     underflow = 1 one clk later, tc_pulse high for 1 clk.
//  3. Auto-reload, up, load 253 -> ticks give 254, 255, then 253.
//     overflow = 1; clr_overflow pulse -> 0 next clk.
//  4. One-shot, down, load 2 -> 1, 0, 255, then holds 255.
//     running = 0; further ticks ignored; load 5 -> running = 1, count = 5.
//  5. clr_underflow asserted in the same cycle as a new underflow -> underflow stays 1.
//     load coincident with a wrap tick -> count = start_counter, no flag.
//  6. TIMER_CMP_EN: cmp_val = 3, load 6, down -> cmp_match = 1 after the 3rd tick.
//     Stays set until clr_cmp. Async rst mid-count -> all outputs reset immediately.

Source files
------------

// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the parametrised timer counter:
//   - timer_mode_e : run-mode encodings (free-run, auto-reload, one-shot).
//                    Encoding 2'b11 is treated as free-run.
//   - max_count()  : all-ones value for a given counter width, used to build
//                    the terminal count of an up-counting timer.
// ----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        MODE_FREE     = 2'b00,
        MODE_RELOAD   = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_FREE_ALT = 2'b11
    } timer_mode_e;

    // All-ones value of a width-bit counter (valid for 1 <= width <= 63).
    function automatic logic [63:0] max_count(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage : timer_pkg

// File: rtl/timer_sticky_flag.sv
// ----------------------------------------------------------------------------
// timer_sticky_flag
// Sticky status bit: set by i_set, cleared by i_clr, set wins when both are
// asserted in the same cycle. Async active-high reset clears the flag.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   i_set  in  set request (one cycle)
//   i_clr  in  clear request (one cycle)
//   o_flag out registered flag value
// ----------------------------------------------------------------------------
module timer_sticky_flag (
    input  logic clk,
    input  logic rst,
    input  logic i_set,
    input  logic i_clr,
    output logic o_flag
);

    logic r_flag;

    // Flag register: set has priority over clear so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag <= 1'b0;
        end else if (i_set) begin
            r_flag <= 1'b1;
        end else if (i_clr) begin
            r_flag <= 1'b0;
        end else begin
            r_flag <= r_flag;
        end
    end

    assign o_flag = r_flag;

endmodule : timer_sticky_flag

// File: rtl/timer_counter_param.sv
// ----------------------------------------------------------------------------
// timer_counter_param
// Parametrised up/down timer counter advanced by a one-cycle prescaler tick.
// Run modes: free-run (wrap), auto-reload (reload start_counter on wrap) and
// one-shot (hold wrapped value, stop until next load). Every wrap/reload
// event raises tc_pulse for one cycle and sets the sticky overflow/underflow
// flag.
//
// Optional feature macro: TIMER_CMP_EN
//   When defined, adds cmp_val/clr_cmp inputs and the sticky cmp_match output,
//   set on the edge where a tick or load makes count equal cmp_val.
//
// Parameters:
//   WIDTH    counter / load / compare width (>= 2)
//   RST_VAL  counter value after reset
// Ports:
//   clk, rst                     clock, async active-high reset
//   clk_ena                      count tick (one clk wide)
//   start_counter [WIDTH]        load / reload value
//   load                         load start_counter (ignores clk_ena)
//   up_down                      1 = up, 0 = down
//   enable                       count enable
//   mode [2]                     run mode, see timer_pkg::timer_mode_e
//   clr_overflow, clr_underflow  sticky flag clears
//   count [WIDTH]                current counter value
//   overflow, underflow          sticky wrap flags
//   tc_pulse                     one-cycle wrap/reload pulse
//   running                      counting permitted (0 after one-shot expiry)
// ----------------------------------------------------------------------------
module timer_counter_param
    import timer_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
`ifdef TIMER_CMP_EN
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             clr_cmp,
    output logic             cmp_match,
`endif
    input  logic             clk_ena,
    input  logic [WIDTH-1:0] start_counter,
    input  logic             load,
    input  logic             up_down,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             clr_overflow,
    input  logic             clr_underflow,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    output logic             underflow,
    output logic             tc_pulse,
    output logic             running
);

    localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(max_count(WIDTH));
    localparam logic [WIDTH-1:0] ZERO_CNT = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_CNT  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_running;
    logic             r_tc;

    logic [WIDTH-1:0] w_count_step;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_running_nxt;
    logic             w_tick;
    logic             w_at_limit;
    logic             w_wrap;

    assign w_tick       = enable & clk_ena & r_running;
    // Modulo arithmetic already yields the wrapped value (max->0, 0->max).
    assign w_count_step = up_down ? (r_count + ONE_CNT) : (r_count - ONE_CNT);
    assign w_at_limit   = up_down ? (r_count == MAX_CNT) : (r_count == ZERO_CNT);
    // A load in the same cycle suppresses the wrap event entirely.
    assign w_wrap       = w_tick & w_at_limit & ~load;

    // Next-state selection: load > tick > hold.
    always_comb begin
        w_count_nxt   = r_count;
        w_running_nxt = r_running;
        if (load) begin
            w_count_nxt   = start_counter;
            w_running_nxt = 1'b1;
        end else if (w_tick) begin
            if (w_wrap) begin
                case (timer_mode_e'(mode))
                    MODE_RELOAD: begin
                        w_count_nxt = start_counter;
                    end
                    MODE_ONESHOT: begin
                        w_count_nxt   = w_count_step;
                        w_running_nxt = 1'b0;
                    end
                    default: begin
                        w_count_nxt = w_count_step;
                    end
                endcase
            end else begin
                w_count_nxt = w_count_step;
            end
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Counter, run state and terminal-count pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= RST_VAL;
            r_running <= 1'b1;
            r_tc      <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_running <= w_running_nxt;
            r_tc      <= w_wrap;
        end
    end

    timer_sticky_flag u_ovf_flag (
        .clk    (clk),
        .rst    (rst),
        .i_set  (w_wrap & up_down),
        .i_clr  (clr_overflow),
        .o_flag (overflow)
    );

    timer_sticky_flag u_unf_flag (
        .clk    (clk),
        .rst    (rst),
        .i_set  (w_wrap & ~up_down),
        .i_clr  (clr_underflow),
        .o_flag (underflow)
    );

`ifdef TIMER_CMP_EN
    logic w_cmp_set;
    // Match is judged on the value the counter is about to take.
    assign w_cmp_set = (load | w_tick) & (w_count_nxt == cmp_val);

    timer_sticky_flag u_cmp_flag (
        .clk    (clk),
        .rst    (rst),
        .i_set  (w_cmp_set),
        .i_clr  (clr_cmp),
        .o_flag (cmp_match)
    );
`endif

    assign count    = r_count;
    assign running  = r_running;
    assign tc_pulse = r_tc;

endmodule : timer_counter_param

// File: tb/tb_timer_counter_param.sv
// ----------------------------------------------------------------------------
// tb_timer_counter_param
// Directed bench for timer_counter_param (WIDTH = 8, clk_ena every 2nd clk).
// A behavioural model tracks the counter in plain integer arithmetic and is
// compared against the DUT on every falling clock edge; literal expectations
// at key points pin both the DUT and the model.
// ----------------------------------------------------------------------------
module tb_timer_counter_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_ena = 1'b0;
    logic [7:0] start_counter = 8'd0;
    logic       load = 1'b0;
    logic       up_down = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       clr_overflow = 1'b0;
    logic       clr_underflow = 1'b0;
    logic [7:0] count;
    logic       overflow, underflow, tc_pulse, running;
`ifdef TIMER_CMP_EN
    logic [7:0] cmp_val = 8'd200;
    logic       clr_cmp = 1'b0;
    logic       cmp_match;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    timer_counter_param #(.WIDTH(8), .RST_VAL(8'd0)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef TIMER_CMP_EN
        .cmp_val       (cmp_val),
        .clr_cmp       (clr_cmp),
        .cmp_match     (cmp_match),
`endif
        .clk_ena       (clk_ena),
        .start_counter (start_counter),
        .load          (load),
        .up_down       (up_down),
        .enable        (enable),
        .mode          (mode),
        .clr_overflow  (clr_overflow),
        .clr_underflow (clr_underflow),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow),
        .tc_pulse      (tc_pulse),
        .running       (running)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_count;
    logic       m_ovf, m_unf, m_tc, m_run, m_cmp;
    logic [7:0] m_nxt;
    int         m_v;
    bit         m_tick, m_wrap;

    always_comb begin
        m_tick = enable && clk_ena && m_run;
        m_v    = up_down ? int'(m_count) + 1 : int'(m_count) - 1;
        m_wrap = m_tick && !load && (m_v < 0 || m_v > 255);
        if (load)                          m_nxt = start_counter;
        else if (!m_tick)                  m_nxt = m_count;
        else if (m_wrap && mode == 2'b01)  m_nxt = start_counter;
        else                               m_nxt = 8'((m_v + 256) % 256);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count <= 8'd0;
            m_ovf   <= 1'b0;
            m_unf   <= 1'b0;
            m_tc    <= 1'b0;
            m_run   <= 1'b1;
            m_cmp   <= 1'b0;
        end else begin
            m_count <= m_nxt;
            m_tc    <= m_wrap;
            if (load) m_run <= 1'b1;
            else if (m_wrap && mode == 2'b10) m_run <= 1'b0;
            m_ovf <= (m_wrap && up_down)  || (m_ovf && !clr_overflow);
            m_unf <= (m_wrap && !up_down) || (m_unf && !clr_underflow);
`ifdef TIMER_CMP_EN
            m_cmp <= ((load || m_tick) && m_nxt == cmp_val) || (m_cmp && !clr_cmp);
`endif
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("cyc_count",     count,     m_count);
        check("cyc_overflow",  overflow,  m_ovf);
        check("cyc_underflow", underflow, m_unf);
        check("cyc_tc_pulse",  tc_pulse,  m_tc);
        check("cyc_running",   running,   m_run);
`ifdef TIMER_CMP_EN
        check("cyc_cmp_match", cmp_match, m_cmp);
`endif
    end

    // ---------------- stimulus helpers ----------------
    // One clock; clk_ena toggles just after each edge (tick every 2nd clk).
    task automatic cyc();
        @(posedge clk);
        #1;
        clk_ena = ~clk_ena;
    endtask

    // Make the next edge a tick edge.
    task automatic align();
        if (clk_ena == 1'b0) cyc();
    endtask

    task automatic ntick(input int k);
        repeat (k) begin
            align();
            cyc();
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        start_counter = v;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        // 1. reset
        rst = 1'b1;
        repeat (5) cyc();
        rst = 1'b0;
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        check("rst_tc", tc_pulse, 0);
        check("rst_running", running, 1);

        // 2. free-run down from 10
        mode = 2'b00; up_down = 1'b0;
        align();
        enable = 1'b1;
        do_load(8'd10);
        check("t2_load_no_dec", count, 10);
        ntick(10);
        check("t2_reach0", count, 0);
        check("t2_no_unf", underflow, 0);
        ntick(1);
        check("t2_wrap_count", count, 255);
        check("t2_unf", underflow, 1);
        check("t2_tc", tc_pulse, 1);
        check("t2_model_count", m_count, 255);
        cyc();
        check("t2_tc_one_clk", tc_pulse, 0);

        // 3. auto-reload up from 253
        mode = 2'b01; up_down = 1'b1;
        do_load(8'd253);
        ntick(1); check("t3_254", count, 254);
        ntick(1); check("t3_255", count, 255);
        ntick(1); check("t3_reload", count, 253);
        check("t3_ovf", overflow, 1);
        check("t3_tc", tc_pulse, 1);
        check("t3_model_reload", m_count, 253);
        clr_overflow = 1'b1; cyc(); clr_overflow = 1'b0;
        check("t3_ovf_clr", overflow, 0);

        // 4. one-shot down from 2
        clr_underflow = 1'b1; cyc(); clr_underflow = 1'b0;
        mode = 2'b10; up_down = 1'b0;
        do_load(8'd2);
        ntick(1); check("t4_1", count, 1);
        ntick(1); check("t4_0", count, 0);
        ntick(1); check("t4_255", count, 255);
        check("t4_stopped", running, 0);
        check("t4_model_stopped", m_run, 0);
        ntick(2); check("t4_hold", count, 255);
        do_load(8'd5);
        check("t4_reload_run", running, 1);
        check("t4_reload_cnt", count, 5);

        // 5a. clear coincident with a new underflow: set wins
        clr_underflow = 1'b1; cyc(); clr_underflow = 1'b0;
        mode = 2'b00;
        do_load(8'd0);
        align();
        clr_underflow = 1'b1; cyc(); clr_underflow = 1'b0;
        check("t5_set_wins", underflow, 1);
        check("t5_wrap", count, 255);
        // 5b. load coincident with a wrap tick
        clr_underflow = 1'b1; cyc(); clr_underflow = 1'b0;
        do_load(8'd0);
        align();
        do_load(8'd77);
        check("t5_load_wins", count, 77);
        check("t5_no_flag", underflow, 0);
        check("t5_no_tc", tc_pulse, 0);

`ifdef TIMER_CMP_EN
        // 6a. compare match
        cmp_val = 8'd3;
        clr_cmp = 1'b1; cyc(); clr_cmp = 1'b0;
        do_load(8'd6);
        ntick(2);
        check("t6_no_match", cmp_match, 0);
        ntick(1);
        check("t6_cnt3", count, 3);
        check("t6_match", cmp_match, 1);
        ntick(2);
        check("t6_sticky", cmp_match, 1);
        clr_cmp = 1'b1; cyc(); clr_cmp = 1'b0;
        check("t6_clr", cmp_match, 0);
`endif

        // 6b. async reset mid-count after one-shot expiry
        mode = 2'b10; up_down = 1'b0;
        do_load(8'd0);
        ntick(1);
        check("t6_pre_cnt", count, 255);
        check("t6_pre_run", running, 0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_arst_count", count, 0);
        check("t6_arst_unf", underflow, 0);
        check("t6_arst_ovf", overflow, 0);
        check("t6_arst_tc", tc_pulse, 0);
        check("t6_arst_run", running, 1);
`ifdef TIMER_CMP_EN
        check("t6_arst_cmp", cmp_match, 0);
`endif
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        enable = 1'b0;
        #20;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_timer_counter_param
